// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB boundary: writeback source select and load types.
package wb_pkg;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_IMM  = 2'd1,
    WD_PC4  = 2'd2,
    WD_DRAM = 2'd3
  } wd_sel_e;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Byte/half/word lane selection and sign/zero extension of a raw DRAM read word.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_ld_type,
  output logic [XLEN-1:0] o_data
);

  logic        [31:0] w_word;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;
  logic signed [31:0] w_word_s;

  assign w_word   = i_rdata[31:0];
  assign w_byte   = w_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half   = i_addr_lo[1] ? w_word[31:16] : w_word[15:0];
  assign w_word_s = w_word;

  // Unlisted funct3 codes pass the raw word through untouched.
  always_comb begin
    o_data = i_rdata;
    case (i_ld_type)
      LD_B:    o_data = XLEN'(w_byte);
      LD_H:    o_data = XLEN'(w_half);
      LD_W:    o_data = XLEN'(w_word_s);
      LD_BU:   o_data = XLEN'($unsigned(w_byte));
      LD_HU:   o_data = XLEN'($unsigned(w_half));
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: writeback source mux, load extension, retire pulse and counter.
module mem_wb_pipe
  import wb_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'($signed(32'hFFFF_FFFC)),
  parameter int              CNT_W    = 32
) (
  input  logic             clk_cpu,
  input  logic             rst_cpu,
  input  logic             valid_mem,
  input  logic             flush_mem,
  input  logic             stall_wb,
  input  logic             rd_we_mem,
  input  logic [1:0]       wd_sel_mem,
  input  logic [2:0]       ld_type_mem,
  input  logic [XLEN-1:0]  dram_rdata_mem,
  input  logic [XLEN-1:0]  alu_mem,
  input  logic [XLEN-1:0]  imm_mem,
  input  logic [XLEN-1:0]  pc_mem,
  input  logic [4:0]       rd_mem,
  output logic             rd_we_wb,
  output logic [4:0]       rd_wb,
  output logic [XLEN-1:0]  data_wb,
  output logic [XLEN-1:0]  pc_wb,
  output logic             have_inst,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [XLEN-1:0] w_ld_data;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_wd;
  logic            w_take;

  logic             r_rd_we_p1;
  logic [4:0]       r_rd_p1;
  logic [XLEN-1:0]  r_data_p1;
  logic [XLEN-1:0]  r_pc_p1;
  logic             r_vld_p1;
  logic [CNT_W-1:0] r_retire_cnt;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .i_rdata   (dram_rdata_mem),
    .i_addr_lo (alu_mem[1:0]),
    .i_ld_type (ld_type_mem),
    .o_data    (w_ld_data)
  );

  assign w_pc4  = pc_mem + XLEN'(4);
  assign w_take = valid_mem && !flush_mem;

  always_comb begin
    w_wd = alu_mem;
    case (wd_sel_mem)
      WD_ALU:  w_wd = alu_mem;
      WD_IMM:  w_wd = imm_mem;
      WD_PC4:  w_wd = w_pc4;
      WD_DRAM: w_wd = w_ld_data;
      default: w_wd = alu_mem;
    endcase
  end

  // ---- MEM -> WB boundary (p1) ----
  // Stall holds everything but drops the retire pulse so one instruction counts once.
  always_ff @(posedge clk_cpu) begin
    if (rst_cpu) begin
      r_rd_we_p1   <= 1'b0;
      r_rd_p1      <= '0;
      r_data_p1    <= '0;
      r_pc_p1      <= RESET_PC;
      r_vld_p1     <= 1'b0;
      r_retire_cnt <= '0;
    end else if (stall_wb) begin
      r_vld_p1     <= 1'b0;
    end else if (w_take) begin
      r_rd_we_p1   <= rd_we_mem && (rd_mem != 5'd0);
      r_rd_p1      <= rd_mem;
      r_data_p1    <= w_wd;
      r_pc_p1      <= pc_mem;
      r_vld_p1     <= 1'b1;
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end else begin
      r_rd_we_p1   <= 1'b0;
      r_rd_p1      <= '0;
      r_data_p1    <= '0;
      r_vld_p1     <= 1'b0;
    end
  end

  assign rd_we_wb   = r_rd_we_p1;
  assign rd_wb      = r_rd_p1;
  assign data_wb    = r_data_p1;
  assign pc_wb      = r_pc_p1;
  assign have_inst  = r_vld_p1;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RESET_PC, default XLEN'hFFFF_FFFC sign-extended, value of pc_wb after reset.
REQ-003 SHALL have parameter CNT_W, default 32, width of the retire counter.
REQ-004 clk_cpu  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_cpu  in  1  reset, synchronous and active-high.
REQ-006 valid_mem  in  1  the MEM stage holds a real instruction.
REQ-007 flush_mem  in  1  kill the MEM-stage instruction; insert a bubble.
REQ-008 stall_wb  in  1  hold the WB register contents.
REQ-009 rd_we_mem  in  1  instruction writes rd.
REQ-010 wd_sel_mem  in  2  writeback source select.
REQ-011 ld_type_mem  in  3  load funct3.
REQ-012 dram_rdata_mem  in  XLEN  raw aligned DRAM read word.
REQ-013 alu_mem  in  XLEN  ALU result or load address.
REQ-014 imm_mem  in  XLEN  immediate.
REQ-015 pc_mem  in  XLEN  instruction PC.
REQ-016 rd_mem  in  5  destination register.
REQ-017 rd_we_wb  out  1  register-file write enable.
REQ-018 rd_wb  out  5  register-file write address.
REQ-019 data_wb  out  XLEN  register-file write data.
REQ-020 pc_wb  out  XLEN  PC of the instruction in WB.
REQ-021 have_inst  out  1  one-cycle retire pulse.
REQ-022 retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-023 Capture condition: a rising edge with rst_cpu=0 and stall_wb=0.
  - "Valid capture" = capture with valid_mem=1 and flush_mem=0.
  - Every other capture is a bubble.
REQ-024 Valid capture loads all outputs as follows:
  - rd_wb = rd_mem; pc_wb = pc_mem.
  - rd_we_wb = rd_we_mem AND (rd_mem != 0).
  - data_wb = selected source.
  - have_inst = 1; retire_cnt increments by 1.
REQ-025 Bubble capture loads:
  - rd_we_wb = 0, rd_wb = 0, data_wb = 0, have_inst = 0.
  - pc_wb holds its value; retire_cnt unchanged.
REQ-026 When stall_wb=1 (and rst_cpu=0):
  - rd_we_wb, rd_wb, data_wb, pc_wb and retire_cnt all hold.
  - have_inst is forced to 0, so a stalled instruction is never counted twice.
REQ-027 Simultaneous stall_wb and flush_mem: stall wins, flush is ignored that cycle; upstream keeps flush_mem asserted until it is consumed.
REQ-028 wd_sel_mem sources:
  - 0: alu_mem.
  - 1: imm_mem.
  - 2: pc_mem + 4, truncated to XLEN (wraps modulo 2^XLEN).
  - 3: load-extended DRAM data.
REQ-029 Load extension, by ld_type_mem:
  - 000 lb: byte lane alu_mem[1:0], sign-extended.
  - 001 lh: half-word lane alu_mem[1], sign-extended.
  - 010 lw: low 32 bits, sign-extended to XLEN.
  - 100 lbu, 101 lhu: as lb/lh, zero-extended.
  - 011, 110, 111: low XLEN bits of dram_rdata_mem unmodified.
REQ-030 retire_cnt wraps from 2^CNT_W-1 to 0 with no flag.
REQ-031 Latency: exactly one cycle from MEM inputs to WB outputs; no combinational path from any input to any output.

Reset
REQ-032 When rst_cpu=1 at a rising edge, the block SHALL load:
  - rd_we_wb = 0, rd_wb = 0, data_wb = 0, have_inst = 0, retire_cnt = 0.
  - pc_wb = RESET_PC.
REQ-033 Reset SHALL override stall_wb, flush_mem and valid_mem, including reset asserted mid-stall.

Structure
REQ-034 Package wb_pkg SHALL hold:
  - wd_sel encodings WD_ALU, WD_IMM, WD_PC4, WD_DRAM.
  - Load-type codes LD_B, LD_H, LD_W, LD_BU, LD_HU.
REQ-035 Byte/half selection and extension SHALL be one combinational sub-module, load_ext, parameterised by XLEN.

Verification
REQ-036 Reset: rst_cpu=1 for one edge with stall_wb=1 -> pc_wb=FFFF_FFFC, retire_cnt=0, rd_we_wb=0, have_inst=0.
REQ-037 Load extension (alu_mem=0x1003, dram_rdata_mem=0x80FF_FF7F, wd_sel=3, rd=5, rd_we=1):
  - lb -> data_wb=FFFF_FF80; lbu -> 0000_0080.
  - Each capture gives rd_we_wb=1, a one-cycle have_inst pulse and retire_cnt+1.
REQ-038 Stall: capture pc_mem=0x100, then stall_wb=1 for 3 cycles with pc_mem=0x104:
  - During the stall: pc_wb stays 0x100, have_inst=0, retire_cnt unchanged.
  - After release: pc_wb=0x104 and retire_cnt+1.
REQ-039 Flush and priority:
  - valid_mem=1 with flush_mem=1 -> rd_we_wb=0, data_wb=0, have_inst=0, pc_wb held.
  - stall_wb=1 with flush_mem=1 -> all outputs held.
REQ-040 Edge cases:
  - rd_mem=0, rd_we_mem=1, wd_sel=2, pc_mem=FFFF_FFFC -> rd_we_wb=0, data_wb=0000_0000, have_inst=1.
  - With CNT_W=4, 16 valid captures -> retire_cnt=0.
